// File: rtl/array_output_drain.sv
// ---------------------------------------------------------------------------
// array_output_drain
//
// Collects the results held by the per-column output controllers of the
// systolic array and puts them on one valid/ready stream. The columns are
// read in column-major order: column 0 rows 0..ROWS-1, then column 1, and so
// on. Each word is read through the column's rvalid/rread handshake and
// written into a small first-word-fall-through FIFO. The (col,row) position
// travels with the word, and the last word of the tile is flagged.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous reset, active high
//   col_r      : head result of each column controller
//   col_v      : rvalid of each column controller
//   col_rread  : read strobe to the column controllers (one-hot or zero)
//   out_data   : stream data (FIFO head)
//   out_col    : column index of out_data
//   out_row    : row index of out_data
//   out_last   : out_data is the last word of the tile (COLS-1, ROWS-1)
//   out_valid  : FIFO holds at least one word
//   out_ready  : consumer accepts the word when out_valid && out_ready
//   tile_done  : one-cycle pulse once the last word of the tile has left
//   busy       : a tile is being drained or flushed
// ---------------------------------------------------------------------------
module array_output_drain #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int OUTWIDTH   = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OUTWIDTH-1:0] col_r [0:COLS-1],
  input  logic [COLS-1:0]     col_v,
  output logic [COLS-1:0]     col_rread,
  output logic [OUTWIDTH-1:0] out_data,
  output logic [CW-1:0]       out_col,
  output logic [RW-1:0]       out_row,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                tile_done,
  output logic                busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [OUTWIDTH-1:0] data;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic                last;
  } entry_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic          tile_done_q, tile_done_d;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic   fifo_empty;
  logic   fifo_full;
  logic   fifo_pop;
  logic   can_push;
  logic   pop;
  logic   at_last;
  entry_t push_entry;
  entry_t head;

  // -------------------------------------------------------------------------
  // Handshake decisions
  // -------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // out_valid is held low during reset so the consumer never takes a word
  // that the same edge is about to discard.
  assign out_valid  = !fifo_empty && !rst;
  assign fifo_pop   = out_valid && out_ready;

  // A full FIFO can still take a word when its head leaves in the same cycle.
  assign can_push   = !fifo_full || fifo_pop;

  // The column pointer never skips: a stalled column holds the whole drain.
  assign pop        = !rst && (state_q == DRAIN) && col_v[cur_col_q] && can_push;

  assign at_last    = (cur_col_q == LAST_COL) && (cur_row_q == LAST_ROW);

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_rread
      assign col_rread[gi] = pop && (cur_col_q == CW'(gi));
    end
  endgenerate

  assign push_entry.data = col_r[cur_col_q];
  assign push_entry.col  = cur_col_q;
  assign push_entry.row  = cur_row_q;
  assign push_entry.last = at_last;

  // -------------------------------------------------------------------------
  // Column / row position of the next read
  // -------------------------------------------------------------------------
  always_comb begin
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    if (pop) begin
      if (cur_row_q == LAST_ROW) begin
        cur_row_d = '0;
        cur_col_d = (cur_col_q == LAST_COL) ? '0 : cur_col_q + 1'b1;
      end else begin
        cur_row_d = cur_row_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tile sequencing
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (col_v[0]) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && at_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Wait for the consumer to take every buffered word of the tile.
        if (fifo_empty) begin
          state_d     = IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({pop, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      tile_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      tile_done_q <= tile_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is cleared on reset so the stream outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (pop) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // -------------------------------------------------------------------------
  // Stream outputs: the FIFO head is presented directly
  // -------------------------------------------------------------------------
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head.data;
  assign out_col   = head.col;
  assign out_row   = head.row;
  assign out_last  = head.last;
  assign tile_done = tile_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_array_output_drain.sv
// ---------------------------------------------------------------------------
// tb_array_output_drain
//
// Bench for array_output_drain. A short table of vectors covers reset and
// idle behaviour. The column controllers are then modelled as queues of
// pending results, and a scoreboard holds the words of each tile in
// column-major order. Every read strobe is checked against the next expected
// column, and every accepted word against the next expected
// (data, col, row, last).
// ---------------------------------------------------------------------------
module tb_array_output_drain;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] col_r [0:COLS-1];
  logic [7:0]   col_v;
  logic [7:0]   col_rread;
  logic [W-1:0] out_data;
  logic [2:0]   out_col;
  logic [2:0]   out_row;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         tile_done;
  logic         busy;

  always #5 clk = ~clk;

  array_output_drain #(
    .COLS(COLS), .ROWS(ROWS), .OUTWIDTH(W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .col_r(col_r), .col_v(col_v), .col_rread(col_rread),
    .out_data(out_data), .out_col(out_col), .out_row(out_row),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .tile_done(tile_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   col;
    logic [2:0]   row;
    logic         last;
  } word_t;

  typedef struct {
    logic       rst;
    logic [7:0] v;
    logic [7:0] exp_rread;
    logic       exp_valid;
    logic       exp_busy;
  } vec_t;

  // Reference model state
  logic [W-1:0] ctrl_q [COLS][$];
  bit           en [COLS];
  bit           rdy;
  bit           rand_mode;
  word_t        exp_q[$];
  int           rd_col_q[$];
  int           occ;
  int           cyc;
  int           rd_win;
  int           rd_tile;
  int           acc_tile;
  int           done_seen;
  int           last_acc_cyc;
  int           first_acc_cyc;
  int           first_rd_cyc;
  int           latest_acc_cyc;
  bit           done_pending;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic new_test();
    rd_tile      = 0;
    acc_tile     = 0;
    done_seen    = 0;
    done_pending = 1'b0;
    rd_win       = 0;
    rand_mode    = 1'b0;
    first_rd_cyc = -1;
  endtask

  // Queue one tile into the controllers and the scoreboard.
  task automatic load_tile(input bit random_data);
    logic [W-1:0] d;
    word_t w;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        d = random_data ? W'($urandom) : W'(c * 16 + r);
        ctrl_q[c].push_back(d);
        rd_col_q.push_back(c);
        w.data = d;
        w.col  = 3'(c);
        w.row  = 3'(r);
        w.last = (c == COLS - 1) && (r == ROWS - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  // One clock cycle with model-driven controllers and consumer.
  task automatic run_cycle();
    logic [7:0] rd;
    bit         acc;
    int         c;
    word_t      w;
    if (rand_mode) begin
      rdy = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < COLS; i++) en[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < COLS; i++) begin
      col_v[i] = en[i] && (ctrl_q[i].size() > 0);
      col_r[i] = (ctrl_q[i].size() > 0) ? ctrl_q[i][0] : '0;
    end
    out_ready = rdy;
    @(negedge clk);
    cyc++;
    rd  = col_rread;
    acc = out_valid && out_ready;
    c   = 0;
    if (rd != 8'h00) begin
      for (int i = COLS - 1; i >= 0; i--) if (rd[i]) c = i;
      chk("rread_onehot", 64'($countones(rd)), 64'd1);
      if (rd_col_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rread_extra: got col %0d expected no read (cycle %0d)", c, cyc);
      end else begin
        chk("rread_col", 64'(c), 64'(rd_col_q[0]));
        chk("rread_valid", 64'(col_v[c]), 64'd1);
        chk("rread_room", 64'((occ < DEPTH) || acc), 64'd1);
      end
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      rd_win++;
      rd_tile++;
    end
    if (acc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_extra: got %0h expected no word (cycle %0d)", out_data, cyc);
      end else begin
        w = exp_q.pop_front();
        chk("word", {25'd0, out_data, out_col, out_row, out_last},
                    {25'd0, w.data, w.col, w.row, w.last});
        if (w.last) begin
          done_pending = 1'b1;
          last_acc_cyc = cyc;
        end
      end
      if (acc_tile == 0) first_acc_cyc = cyc;
      latest_acc_cyc = cyc;
      acc_tile++;
    end
    if (tile_done) begin
      chk("tile_done_timing",
          64'(done_pending && (cyc - last_acc_cyc >= 1) && (cyc - last_acc_cyc <= 2)), 64'd1);
      done_pending = 1'b0;
      done_seen++;
    end
    @(posedge clk);
    #1;
    if (rd != 8'h00 && rd_col_q.size() > 0) begin
      if (ctrl_q[c].size() > 0) void'(ctrl_q[c].pop_front());
      void'(rd_col_q.pop_front());
      occ++;
    end
    if (acc && occ > 0) occ--;
  endtask

  task automatic drain_until(input int exp_done, input int budget);
    int start;
    start = cyc;
    while ((exp_q.size() > 0 || done_seen < exp_done) && (cyc - start < budget)) run_cycle();
    chk("drain_in_budget", 64'(exp_q.size() == 0 && done_seen >= exp_done), 64'd1);
    rand_mode = 1'b0;
    rdy       = 1'b1;
    repeat (3) run_cycle();
    chk("done_count", 64'(done_seen), 64'(exp_done));
    chk("busy_after_tile", 64'(busy), 64'd0);
  endtask

  vec_t vecs [15];

  initial begin
    int guard;

    // rst, col_v -> expected col_rread, out_valid, busy (out_ready held low)
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFE, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'hFE, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'hFE, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h01, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h01, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h01, 8'h01, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    cyc = 0;
    occ = 0;
    rdy = 1'b0;
    rand_mode = 1'b0;
    rst = 1'b1;
    out_ready = 1'b0;
    col_v = 8'hFF;
    for (int i = 0; i < COLS; i++) begin
      col_r[i] = W'(32'hA0 + i);
      en[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;

    // T1 and idle/reset vectors
    for (int k = 0; k < 15; k++) begin
      rst   = vecs[k].rst;
      col_v = vecs[k].v;
      @(negedge clk);
      chk($sformatf("vec%0d_rread", k), 64'(col_rread), 64'(vecs[k].exp_rread));
      chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_busy", k), 64'(busy), 64'(vecs[k].exp_busy));
      if (vecs[k].exp_valid) chk($sformatf("vec%0d_data", k), 64'(out_data), 64'h0A0);
      if (k == 1) chk("reset_outputs", {24'd0, out_data, out_col, out_row, out_last, tile_done},
                      64'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // T2 full tile, data = col*16+row, one word per cycle
    new_test();
    rdy = 1'b1;
    load_tile(1'b0);
    drain_until(1, 400);
    chk("t2_words", 64'(acc_tile), 64'd64);
    chk("t2_first_latency", 64'(first_acc_cyc - first_rd_cyc), 64'd1);
    chk("t2_throughput", 64'(latest_acc_cyc - first_acc_cyc), 64'd63);

    // T3 backpressure: empty FIFO, then out_ready low for 10 cycles
    new_test();
    rdy = 1'b1;
    load_tile(1'b1);
    guard = 0;
    while (acc_tile < 10 && guard < 300) begin run_cycle(); guard++; end
    chk("t3_prefill", 64'(acc_tile >= 10), 64'd1);
    for (int i = 0; i < COLS; i++) en[i] = 1'b0;
    repeat (3) run_cycle();
    chk("t3_fifo_drained", 64'(occ), 64'd0);
    for (int i = 0; i < COLS; i++) en[i] = 1'b1;
    rdy = 1'b0;
    rd_win = 0;
    repeat (10) run_cycle();
    chk("t3_reads_in_stall", 64'(rd_win), 64'(DEPTH));
    rdy = 1'b1;
    drain_until(1, 400);
    chk("t3_words", 64'(acc_tile), 64'd64);

    // T4 column 2 rvalid low for 5 cycles mid-column
    new_test();
    rdy = 1'b1;
    load_tile(1'b1);
    guard = 0;
    while (rd_tile < 2 * ROWS + 3 && guard < 300) begin run_cycle(); guard++; end
    chk("t4_reach_col2", 64'(rd_tile), 64'(2 * ROWS + 3));
    en[2] = 1'b0;
    rd_win = 0;
    repeat (5) run_cycle();
    chk("t4_no_reads_while_stalled", 64'(rd_win), 64'd0);
    chk("t4_busy_while_stalled", 64'(busy), 64'd1);
    en[2] = 1'b1;
    drain_until(1, 400);
    chk("t4_words", 64'(acc_tile), 64'd64);

    // T5 reset after 20 accepted words
    new_test();
    rdy = 1'b1;
    load_tile(1'b1);
    guard = 0;
    while (acc_tile < 20 && guard < 300) begin run_cycle(); guard++; end
    chk("t5_reach_20", 64'(acc_tile), 64'd20);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_rread_in_reset", 64'(col_rread), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < COLS; i++) ctrl_q[i].delete();
    exp_q.delete();
    rd_col_q.delete();
    occ = 0;
    col_v = 8'h00;
    @(negedge clk);
    chk("t5_valid_after_reset", 64'(out_valid), 64'd0);
    chk("t5_busy_after_reset", 64'(busy), 64'd0);
    chk("t5_outputs_after_reset", {24'd0, out_data, out_col, out_row, out_last, tile_done}, 64'd0);
    @(posedge clk);
    #1;
    new_test();
    rdy = 1'b1;
    load_tile(1'b1);
    drain_until(1, 400);
    chk("t5_words", 64'(acc_tile), 64'd64);

    // T6 two tiles back to back, random out_ready and controller stalls
    new_test();
    load_tile(1'b1);
    load_tile(1'b1);
    rand_mode = 1'b1;
    drain_until(2, 3000);
    chk("t6_words", 64'(acc_tile), 64'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
